// File: rtl/data_cache_controller.sv
// Direct-mapped, write-back, write-allocate data cache in front of a word-addressed
// data memory; misses stall the CPU while a dirty victim is written back and the line refilled.
module data_cache_controller #(
  parameter int NUM_LINES      = 8,
  parameter int WORDS_PER_LINE = 4,
  parameter int MEM_ADDR_WIDTH = 6
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      cpu_read,
  input  logic                      cpu_write,
  input  logic [31:0]               cpu_address,
  input  logic [31:0]               cpu_writedata,
  input  logic [3:0]                cpu_byteen,
  output logic [31:0]               cpu_readdata,
  output logic                      cpu_busywait,
  output logic                      mem_read,
  output logic                      mem_write,
  output logic [MEM_ADDR_WIDTH-1:0] mem_address,
  output logic [31:0]               mem_writedata,
  input  logic [31:0]               mem_readdata,
  input  logic                      mem_ready
);

  localparam int INDEX_W = $clog2(NUM_LINES);
  localparam int OFF_W   = $clog2(WORDS_PER_LINE);
  localparam int TAG_W   = MEM_ADDR_WIDTH - INDEX_W - OFF_W;
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS_PER_LINE - 1);
  localparam logic [OFF_W-1:0] BEAT_ONE  = OFF_W'(1'b1);
  localparam logic [OFF_W-1:0] BEAT_ZERO = {OFF_W{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITEBACK = 2'd1,
    ST_FILL      = 2'd2
  } state_t;

  state_t                    state_r, state_nxt_s;
  logic [OFF_W-1:0]          beat_r, beat_nxt_s;
  logic [31:0]               data_r [NUM_LINES][WORDS_PER_LINE];
  logic [TAG_W-1:0]          tag_r  [NUM_LINES];
  logic [NUM_LINES-1:0]      valid_r;
  logic [NUM_LINES-1:0]      dirty_r;

  logic [OFF_W-1:0]          offset_s;
  logic [INDEX_W-1:0]        index_s;
  logic [TAG_W-1:0]          tag_s;
  logic                      rd_req_s, wr_req_s, req_s, hit_s;
  logic                      write_hit_s, fill_we_s, fill_last_s;
  logic                      mem_read_nxt_s, mem_write_nxt_s;
  logic [MEM_ADDR_WIDTH-1:0] mem_address_nxt_s;
  logic [31:0]               mem_writedata_nxt_s;
  logic                      unused_addr_bits_s;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  byteen);
    logic [31:0] merged;
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (byteen[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

  assign offset_s = cpu_address[OFF_W+1:2];
  assign index_s  = cpu_address[OFF_W+INDEX_W+1:OFF_W+2];
  assign tag_s    = cpu_address[MEM_ADDR_WIDTH+1:OFF_W+INDEX_W+2];
  assign unused_addr_bits_s = ^{cpu_address[31:MEM_ADDR_WIDTH+2], cpu_address[1:0]};

  // Both strobes high is treated as no request at all.
  assign rd_req_s    = cpu_read & ~cpu_write;
  assign wr_req_s    = cpu_write & ~cpu_read;
  assign req_s       = rd_req_s | wr_req_s;
  assign hit_s       = valid_r[index_s] && (tag_r[index_s] == tag_s);
  assign write_hit_s = wr_req_s && hit_s && (state_r == ST_IDLE);
  assign fill_we_s   = (state_r == ST_FILL) && mem_ready;
  assign fill_last_s = fill_we_s && (beat_r == LAST_BEAT);

  // CPU-facing stall and load data
  always_comb begin
    cpu_busywait = 1'b0;
    cpu_readdata = 32'h0;
    if (reset) begin
      cpu_busywait = req_s && ((state_r != ST_IDLE) || !hit_s);
      if (rd_req_s && hit_s && (state_r == ST_IDLE)) begin
        cpu_readdata = data_r[index_s][offset_s];
      end else begin
        cpu_readdata = 32'h0;
      end
    end else begin
      cpu_busywait = 1'b0;
    end
  end

  // Next-state and beat counter
  always_comb begin
    state_nxt_s = state_r;
    beat_nxt_s  = beat_r;
    case (state_r)
      ST_IDLE: begin
        beat_nxt_s = BEAT_ZERO;
        if (req_s && !hit_s) begin
          if (valid_r[index_s] && dirty_r[index_s]) begin
            state_nxt_s = ST_WRITEBACK;
          end else begin
            state_nxt_s = ST_FILL;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WRITEBACK: begin
        if (mem_ready) begin
          if (beat_r == LAST_BEAT) begin
            state_nxt_s = ST_FILL;
            beat_nxt_s  = BEAT_ZERO;
          end else begin
            beat_nxt_s  = beat_r + BEAT_ONE;
          end
        end else begin
          beat_nxt_s = beat_r;
        end
      end
      ST_FILL: begin
        if (mem_ready) begin
          if (beat_r == LAST_BEAT) begin
            state_nxt_s = ST_IDLE;
            beat_nxt_s  = BEAT_ZERO;
          end else begin
            beat_nxt_s  = beat_r + BEAT_ONE;
          end
        end else begin
          beat_nxt_s = beat_r;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        beat_nxt_s  = BEAT_ZERO;
      end
    endcase
  end

  // Memory request for the upcoming cycle, computed from the next state so the outputs can be registered
  always_comb begin
    mem_read_nxt_s      = 1'b0;
    mem_write_nxt_s     = 1'b0;
    mem_address_nxt_s   = {MEM_ADDR_WIDTH{1'b0}};
    mem_writedata_nxt_s = 32'h0;
    case (state_nxt_s)
      ST_WRITEBACK: begin
        mem_write_nxt_s     = 1'b1;
        mem_address_nxt_s   = {tag_r[index_s], index_s, beat_nxt_s};
        mem_writedata_nxt_s = data_r[index_s][beat_nxt_s];
      end
      ST_FILL: begin
        mem_read_nxt_s    = 1'b1;
        mem_address_nxt_s = {tag_s, index_s, beat_nxt_s};
      end
      default: begin
        mem_read_nxt_s  = 1'b0;
        mem_write_nxt_s = 1'b0;
      end
    endcase
  end

  // FSM, beat counter and registered memory interface
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r       <= ST_IDLE;
      beat_r        <= BEAT_ZERO;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      mem_address   <= {MEM_ADDR_WIDTH{1'b0}};
      mem_writedata <= 32'h0;
    end else begin
      state_r       <= state_nxt_s;
      beat_r        <= beat_nxt_s;
      mem_read      <= mem_read_nxt_s;
      mem_write     <= mem_write_nxt_s;
      mem_address   <= mem_address_nxt_s;
      mem_writedata <= mem_writedata_nxt_s;
    end
  end

  // Line status bits
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_r <= {NUM_LINES{1'b0}};
      dirty_r <= {NUM_LINES{1'b0}};
    end else if (fill_last_s) begin
      valid_r[index_s] <= 1'b1;
      dirty_r[index_s] <= 1'b0;
    end else if (write_hit_s) begin
      dirty_r[index_s] <= 1'b1;
    end
  end

  // Data and tag storage; contents survive reset because valid bits gate their use
  always_ff @(posedge clock) begin
    if (fill_we_s) begin
      data_r[index_s][beat_r] <= mem_readdata;
      if (fill_last_s) tag_r[index_s] <= tag_s;
    end else if (write_hit_s) begin
      data_r[index_s][offset_s] <= merge_bytes(data_r[index_s][offset_s], cpu_writedata, cpu_byteen);
    end
  end

endmodule

// File: tb/tb_data_cache_controller.sv
// Directed bench for data_cache_controller with a behavioural word memory whose
// ready spacing is adjustable; expected values are hand-computed constants.
module tb_data_cache_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic        cpu_read, cpu_write;
  logic [31:0] cpu_address, cpu_writedata;
  logic [3:0]  cpu_byteen;
  logic [31:0] cpu_readdata;
  logic        cpu_busywait;
  logic        mem_read, mem_write;
  logic [5:0]  mem_address;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;
  logic        mem_ready;

  int total = 0;
  int bad   = 0;
  int gap   = 0;
  int wait_cnt = 0;
  logic [31:0] mem_model [64];
  logic [31:0] wr_addrs[$];
  logic [31:0] wr_data[$];
  logic [31:0] rd_addrs[$];

  data_cache_controller dut (
    .clock(clock), .reset(reset),
    .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_address(cpu_address),
    .cpu_writedata(cpu_writedata), .cpu_byteen(cpu_byteen),
    .cpu_readdata(cpu_readdata), .cpu_busywait(cpu_busywait),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata), .mem_ready(mem_ready)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Memory responder: serves one beat every (gap+1) cycles while a request is up
  initial begin
    mem_ready    = 1'b0;
    mem_readdata = 32'h0;
    forever begin
      @(negedge clock);
      mem_ready = 1'b0;
      if (reset && (mem_read || mem_write)) begin
        if (wait_cnt >= gap) begin
          wait_cnt = 0;
          if (mem_write) begin
            mem_model[mem_address] = mem_writedata;
            wr_addrs.push_back({26'h0, mem_address});
            wr_data.push_back(mem_writedata);
          end else begin
            mem_readdata = mem_model[mem_address];
            rd_addrs.push_back({26'h0, mem_address});
          end
          mem_ready = 1'b1;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] be,
                        output logic [31:0] rdata, output int stall);
    stall = 0;
    @(negedge clock);
    cpu_read = rd; cpu_write = wr; cpu_address = addr; cpu_writedata = wd; cpu_byteen = be;
    #1;
    while (cpu_busywait && stall < 200) begin
      @(negedge clock);
      #1;
      stall++;
    end
    check_val("no_timeout", (stall < 200) ? 32'd1 : 32'd0, 32'd1);
    rdata = cpu_readdata;
    @(posedge clock);
    #1;
    cpu_read = 1'b0; cpu_write = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rdat;
    int          stall, nw, nr;

    for (int i = 0; i < 64; i++) mem_model[i] = 32'hA000_0000 + i;
    mem_model[5] = 32'hDEAD_BEEF;
    reset = 1'b0;
    cpu_read = 1'b1; cpu_write = 1'b0; cpu_address = 32'h14;
    cpu_writedata = 32'h0; cpu_byteen = 4'h0;
    #12;
    check_val("rst_busywait", {31'h0, cpu_busywait}, 32'd0);
    check_val("rst_readdata", cpu_readdata, 32'h0);
    check_val("rst_mem_req", {30'h0, mem_read, mem_write}, 32'd0);
    check_val("rst_mem_addr", {26'h0, mem_address}, 32'd0);
    cpu_read = 1'b0;
    @(negedge clock);
    reset = 1'b1;

    // 1: cold read miss, four fill beats, then a hit
    access(1'b1, 1'b0, 32'h14, 32'h0, 4'h0, rdat, stall);
    check_val("t1_data", rdat, 32'hDEAD_BEEF);
    check_val("t1_stall", stall, 32'd5);
    check_val("t1_nrd", rd_addrs.size(), 32'd4);
    for (int i = 0; i < 4; i++) check_val("t1_rd_addr", rd_addrs[i], 32'd4 + i);
    check_val("t1_nwr", wr_addrs.size(), 32'd0);
    access(1'b1, 1'b0, 32'h14, 32'h0, 4'h0, rdat, stall);
    check_val("t1_hit_data", rdat, 32'hDEAD_BEEF);
    check_val("t1_hit_stall", stall, 32'd0);

    // 2: partial write hit, no memory traffic
    nr = rd_addrs.size(); nw = wr_addrs.size();
    access(1'b0, 1'b1, 32'h14, 32'h1122_3344, 4'b0011, rdat, stall);
    check_val("t2_stall", stall, 32'd0);
    access(1'b1, 1'b0, 32'h14, 32'h0, 4'h0, rdat, stall);
    check_val("t2_merged", rdat, 32'hDEAD_3344);
    check_val("t2_no_mem", rd_addrs.size() + wr_addrs.size(), nr + nw);

    // 3: conflicting tag forces writeback of dirty line then refill
    access(1'b1, 1'b0, 32'h94, 32'h0, 4'h0, rdat, stall);
    check_val("t3_data", rdat, 32'hA000_0025);
    check_val("t3_stall", stall, 32'd9);
    check_val("t3_nwr", wr_addrs.size(), 32'd4);
    for (int i = 0; i < 4; i++) check_val("t3_wr_addr", wr_addrs[i], 32'd4 + i);
    check_val("t3_wr_w5", wr_data[1], 32'hDEAD_3344);
    check_val("t3_wr_w4", wr_data[0], 32'hA000_0004);
    check_val("t3_nrd", rd_addrs.size(), 32'd8);
    for (int i = 0; i < 4; i++) check_val("t3_rd_addr", rd_addrs[4+i], 32'd36 + i);

    // 4: both strobes high is ignored
    nr = rd_addrs.size(); nw = wr_addrs.size();
    access(1'b1, 1'b1, 32'h60, 32'hFFFF_FFFF, 4'hF, rdat, stall);
    check_val("t4_stall", stall, 32'd0);
    check_val("t4_rdata", rdat, 32'h0);
    access(1'b1, 1'b1, 32'h94, 32'hFFFF_FFFF, 4'hF, rdat, stall);
    access(1'b1, 1'b0, 32'h94, 32'h0, 4'h0, rdat, stall);
    check_val("t4_unchanged", rdat, 32'hA000_0025);
    check_val("t4_hit_stall", stall, 32'd0);
    check_val("t4_no_mem", rd_addrs.size() + wr_addrs.size(), nr + nw);

    // 6: widely spaced ready pulses
    gap = 4;
    nr = rd_addrs.size();
    access(1'b1, 1'b0, 32'h48, 32'h0, 4'h0, rdat, stall);
    check_val("t6_data", rdat, 32'hA000_0012);
    check_val("t6_stall", stall, 32'd21);
    check_val("t6_nrd", rd_addrs.size(), nr + 4);
    for (int i = 0; i < 4; i++) check_val("t6_rd_addr", rd_addrs[nr+i], 32'd16 + i);
    gap = 0;

    // 5: reset during second fill beat aborts the miss
    nr = rd_addrs.size();
    @(negedge clock);
    cpu_read = 1'b1; cpu_address = 32'h20;
    for (int i = 0; i < 50; i++) begin
      @(posedge clock);
      #1;
      if (rd_addrs.size() > nr) break;
    end
    check_val("t5_first_beat", rd_addrs.size(), nr + 1);
    check_val("t5_beat2_addr", {26'h0, mem_address}, 32'd9);
    reset = 1'b0;
    #1;
    check_val("t5_rst_mem_read", {31'h0, mem_read}, 32'd0);
    check_val("t5_rst_mem_addr", {26'h0, mem_address}, 32'd0);
    check_val("t5_rst_busy", {31'h0, cpu_busywait}, 32'd0);
    check_val("t5_rst_rdata", cpu_readdata, 32'h0);
    repeat (2) @(negedge clock);
    cpu_read = 1'b0;
    reset = 1'b1;
    nr = rd_addrs.size();
    access(1'b1, 1'b0, 32'h20, 32'h0, 4'h0, rdat, stall);
    check_val("t5_data", rdat, 32'hA000_0008);
    check_val("t5_stall", stall, 32'd5);
    check_val("t5_nrd", rd_addrs.size(), nr + 4);
    for (int i = 0; i < 4; i++) check_val("t5_rd_addr", rd_addrs[nr+i], 32'd8 + i);
    access(1'b1, 1'b0, 32'h14, 32'h0, 4'h0, rdat, stall);
    check_val("t5_line1_invalid", stall, 32'd5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
